// File: rtl/fetch_unit.sv
// nanoLADA instruction fetch unit.
// Holds the PC, fetches instruction words over a req/ack handshake, presents
// instr/opcode to the decoder and steps the PC (sequential, jump or branch)
// when the datapath signals advance.
// Optional feature macro: FETCH_TIMEOUT_EN adds a fetch watchdog that parks
// the unit in a fault state when memory never acknowledges.
module fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        advance,
   input  logic        sel_pc,
   input  logic        sel_addpc,
   output logic [31:0] pc,
   output logic        fault
);

   localparam logic [1:0] S_RESET = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;
`ifdef FETCH_TIMEOUT_EN
   localparam logic [1:0] S_FAULT = 2'd3;
   localparam int unsigned WAIT_W =
      ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
`endif

   // Word alignment is forced so a misconfigured RESET_PC cannot break it.
   localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_p4;
   logic [31:0] br_off;
   logic [31:0] next_pc;
`ifdef FETCH_TIMEOUT_EN
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [WAIT_W-1:0] wait_inc;
`endif

   // Next PC: jump beats branch beats sequential; all arithmetic wraps.
   always_comb begin
      pc_p4  = pc_q + 32'd4;
      br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
      if (sel_pc) begin
         next_pc = {pc_p4[31:28], instr_q[25:0], 2'b00};
      end else if (sel_addpc) begin
         next_pc = pc_p4 + br_off;
      end else begin
         next_pc = pc_p4;
      end
   end

   // Fetch/issue sequencing; ack is only honoured in S_FETCH and advance
   // (with its sel_* qualifiers) only in S_ISSUE.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
      wait_d   = wait_q;
      wait_inc = wait_q + 1'b1;
`endif
      case (state_q)
         S_RESET: begin
            state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         S_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = S_ISSUE;
`ifdef FETCH_TIMEOUT_EN
               wait_d  = '0;
            end else if (wait_inc == WAIT_W'(TIMEOUT_CYC)) begin
               state_d = S_FAULT;
               wait_d  = wait_inc;
            end else begin
               wait_d  = wait_inc;
`endif
            end
         end
         S_ISSUE: begin
            if (advance) begin
               pc_d    = next_pc;
               state_d = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
               wait_d  = '0;
`endif
            end
         end
`ifdef FETCH_TIMEOUT_EN
         S_FAULT: begin
            state_d = S_FAULT;
         end
`endif
         default: begin
            state_d = S_RESET;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_RESET;
         pc_q    <= PC_INIT;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   // Watchdog counter of S_FETCH cycles without acknowledge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign fault = (state_q == S_FAULT);
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYC;
   assign fault          = 1'b0;
`endif

   // Outputs decode directly from state so reset drops req immediately.
   assign imem_req    = (state_q == S_FETCH);
   assign instr_valid = (state_q == S_ISSUE);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/issue traffic compared against a behavioural PC model.
module tb_fetch_unit;

   logic        clk;
   logic        reset_n;
   logic        ack, advance, sel_pc, sel_addpc;
   logic [31:0] rdata;
   logic        imem_req, instr_valid, fault;
   logic [31:0] imem_addr, instr, pc;
   logic [5:0]  opcode;

   logic        h_ack, h_advance, h_sel_pc, h_sel_addpc;
   logic [31:0] h_rdata;
   logic        h_req, h_valid, h_fault;
   logic [31:0] h_addr, h_instr, h_pc;
   logic [5:0]  h_opcode;

   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_instr;

   fetch_unit dut (
      .clk(clk), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(ack), .imem_rdata(rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
      .advance(advance), .sel_pc(sel_pc), .sel_addpc(sel_addpc),
      .pc(pc), .fault(fault)
   );

   fetch_unit #(.RESET_PC(32'h4000_0000), .TIMEOUT_CYC(4000)) dut_hi (
      .clk(clk), .reset_n(reset_n),
      .imem_req(h_req), .imem_addr(h_addr),
      .imem_ack(h_ack), .imem_rdata(h_rdata),
      .instr(h_instr), .opcode(h_opcode), .instr_valid(h_valid),
      .advance(h_advance), .sel_pc(h_sel_pc), .sel_addpc(h_sel_addpc),
      .pc(h_pc), .fault(h_fault)
   );

`ifdef FETCH_TIMEOUT_EN
   logic        t_zero;
   logic        t_req, t_valid, t_fault;
   logic [31:0] t_addr, t_instr, t_pc;
   logic [5:0]  t_opcode;
   assign t_zero = 1'b0;

   fetch_unit #(.TIMEOUT_CYC(4)) dut_t (
      .clk(clk), .reset_n(reset_n),
      .imem_req(t_req), .imem_addr(t_addr),
      .imem_ack(t_zero), .imem_rdata(32'h0),
      .instr(t_instr), .opcode(t_opcode), .instr_valid(t_valid),
      .advance(t_zero), .sel_pc(t_zero), .sel_addpc(t_zero),
      .pc(t_pc), .fault(t_fault)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Architectural next-PC rule, written from the instruction-set view.
   function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [31:0] ins,
                                              input logic sp, input logic sa);
      int off;
      if (sp) return ((cur + 32'd4) & 32'hF000_0000) | ({6'b0, ins[25:0]} << 2);
      if (sa) begin
         off = $signed(ins[15:0]);
         return cur + 32'd4 + 32'(off * 4);
      end
      return cur + 32'd4;
   endfunction

   // Entered at a negedge with the DUT fetching; leaves it issuing.
   task automatic do_fetch(input int waits, input logic [31:0] word);
      for (int i = 0; i < waits; i++) begin
         ack = 1'b0; rdata = $urandom;
         advance = 1'($urandom); sel_pc = 1'($urandom); sel_addpc = 1'($urandom);
         chk("fetch_req", imem_req, 1);
         chk("fetch_addr", imem_addr, exp_pc);
         chk("fetch_valid", instr_valid, 0);
         @(negedge clk);
      end
      ack = 1'b1; rdata = word;
      advance = 1'($urandom); sel_pc = 1'($urandom); sel_addpc = 1'($urandom);
      chk("ack_req", imem_req, 1);
      chk("ack_addr", imem_addr, exp_pc);
      @(negedge clk);
      ack = 1'b0; advance = 1'b0;
      exp_instr = word;
      chk("issue_valid", instr_valid, 1);
      chk("issue_instr", instr, exp_instr);
      chk("issue_opcode", opcode, {26'b0, exp_instr[31:26]});
      chk("issue_req", imem_req, 0);
      chk("issue_pc", pc, exp_pc);
   endtask

   // Entered at a negedge with the DUT issuing; leaves it fetching.
   task automatic do_issue(input int hold, input logic sp, input logic sa);
      for (int i = 0; i < hold; i++) begin
         ack = 1'($urandom); rdata = $urandom; advance = 1'b0;
         sel_pc = 1'($urandom); sel_addpc = 1'($urandom);
         chk("hold_valid", instr_valid, 1);
         chk("hold_instr", instr, exp_instr);
         chk("hold_req", imem_req, 0);
         @(negedge clk);
      end
      advance = 1'b1; sel_pc = sp; sel_addpc = sa; ack = 1'($urandom); rdata = $urandom;
      @(negedge clk);
      advance = 1'b0; sel_pc = 1'b0; sel_addpc = 1'b0; ack = 1'b0;
      exp_pc = model_next(exp_pc, exp_instr, sp, sa);
      chk("next_pc", pc, exp_pc);
      chk("next_req", imem_req, 1);
      chk("next_valid", instr_valid, 0);
      chk("next_fault", fault, 0);
   endtask

   initial begin
      reset_n = 1'b0; ack = 1'b1; rdata = 32'hDEAD_BEEF;
      advance = 1'b0; sel_pc = 1'b0; sel_addpc = 1'b0;
      h_ack = 1'b0; h_rdata = '0; h_advance = 1'b0; h_sel_pc = 1'b0; h_sel_addpc = 1'b0;
      exp_pc = 32'h0; exp_instr = 32'h0;
      repeat (2) @(negedge clk);

      // Reset values, with a stray ack held during reset.
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_fault", fault, 0);
      ack = 1'b0;
      reset_n = 1'b1;
      chk("rst_release_req", imem_req, 0);
      @(negedge clk);

      // Test 1: three wait cycles, opcode 1.
      do_fetch(3, 32'h0400_0000);
      chk("t1_opcode", opcode, 32'd1);

      // Test 2: sequential run 0,4,8,C.
      do_issue(0, 1'b0, 1'b0);
      chk("t2_addr4", imem_addr, 32'h4);
      do_fetch(0, $urandom);
      do_issue(1, 1'b0, 1'b0);
      chk("t2_addr8", imem_addr, 32'h8);
      do_fetch(2, $urandom);
      do_issue(0, 1'b0, 1'b0);
      chk("t2_addrC", imem_addr, 32'hC);
      do_fetch(1, $urandom);
      do_issue(2, 1'b0, 1'b0);

      // Test 3: branch back two words from 0x10.
      do_fetch(1, 32'h9000_FFFE);
      do_issue(0, 1'b0, 1'b1);
      chk("t3_branch", imem_addr, 32'hC);

      // Wrap: branch below zero, then sequential step back to zero.
      do_fetch(0, 32'h1000_FFFB);
      do_issue(0, 1'b0, 1'b1);
      chk("wrap_neg", imem_addr, 32'hFFFF_FFFC);
      do_fetch(0, 32'h1234_5678);
      do_issue(1, 1'b0, 1'b0);
      chk("wrap_zero", imem_addr, 32'h0);

      // Test 5: reset mid-fetch with ack asserted while in reset.
      do_fetch(1, 32'h2222_3333);
      do_issue(0, 1'b0, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      chk("t5_req_async", imem_req, 0);
      chk("t5_pc", pc, 32'h0);
      chk("t5_instr", instr, 32'h0);
      ack = 1'b1; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("t5_instr_kept", instr, 32'h0);
      chk("t5_valid", instr_valid, 0);
      chk("t5_req", imem_req, 1);
      chk("t5_addr", imem_addr, 32'h0);
      exp_pc = 32'h0;

      // Randomized traffic against the PC model.
      for (int n = 0; n < 24; n++) begin
         do_fetch($urandom_range(0, 3), $urandom);
         do_issue($urandom_range(0, 2), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      end

      // Test 4: jump and branch together from 0x4000_0000, jump wins.
      h_ack = 1'b1; h_rdata = 32'hC000_0010;
      chk("t4_addr", h_addr, 32'h4000_0000);
      chk("t4_req", h_req, 1);
      @(negedge clk);
      h_ack = 1'b0;
      chk("t4_valid", h_valid, 1);
      chk("t4_opcode", h_opcode, 32'h30);
      h_advance = 1'b1; h_sel_pc = 1'b1; h_sel_addpc = 1'b1;
      @(negedge clk);
      h_advance = 1'b0; h_sel_pc = 1'b0; h_sel_addpc = 1'b0;
      chk("t4_jump", h_addr, 32'h4000_0040);
      chk("t4_req_again", h_req, 1);

`ifdef FETCH_TIMEOUT_EN
      // Test 6: watchdog with no acknowledge.
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk("t6_fault_rst", t_fault, 0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("t6_no_fault", t_fault, 0);
         chk("t6_req", t_req, 1);
      end
      @(negedge clk);
      chk("t6_fault", t_fault, 1);
      chk("t6_req_off", t_req, 0);
      repeat (3) @(negedge clk);
      chk("t6_fault_held", t_fault, 1);
      reset_n = 1'b0;
      #1;
      chk("t6_fault_clear", t_fault, 0);
      @(negedge clk);
      reset_n = 1'b1;
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
